// File: rtl/core_pkg.sv
// Shared types and constants for the multicycle core's memory port arbitration.
package core_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} arb_owner_t;

    localparam logic [2:0] WORD_ALIGN_MASK  = 3'b111;
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while fetch waits; hit forces the next fetch grant.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != 4'(STARVE_MAX))) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign hit = (cnt == 4'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and data load/store,
// with data-over-fetch priority and a bounded starvation window for fetch.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata
);

    // state  | meaning
    // IDLE   | arbitrate pending requests, latch the winner's address/data
    // ACCESS | memory cycle: one-cycle store strobe or MEM_LAT-cycle read
    // RESP   | one-cycle done/err pulse to the owner, requests ignored

    arb_state_t  state, stateNxt;
    arb_owner_t  owner, ownerNxt;
    logic [2:0]  accCnt, accCntNxt;
    logic        lane, laneNxt;
    logic [63:0] memAddrNxt, memWdataNxt, dRdataNxt, grantAddr;
    logic [31:0] ifRdataNxt;
    logic        memWrNxt, ifDoneNxt, dDoneNxt, ifErrNxt, dErrNxt;
    logic        starveHit, grantD, grantIf, starveInc, starveClr, misNow;

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starveInc),
        .clr   (starveClr),
        .hit   (starveHit)
    );

    always_comb begin
        grantD    = d_req && (!if_req || !starveHit);
        grantIf   = if_req && !grantD;
        grantAddr = grantD ? d_addr : if_addr;
        misNow    = grantD ? ((d_addr[2:0] & WORD_ALIGN_MASK) != 3'b000)
                           : ((if_addr[1:0] & INSTR_ALIGN_MASK) != 2'b00);
        starveInc = (state == IDLE) && grantD && if_req;
        starveClr = (state == IDLE) && grantIf;
    end

    always_comb begin
        stateNxt    = state;
        ownerNxt    = owner;
        accCntNxt   = accCnt;
        laneNxt     = lane;
        memAddrNxt  = mem_addr;
        memWdataNxt = mem_wdata;
        memWrNxt    = mem_wr;
        ifRdataNxt  = if_rdata;
        dRdataNxt   = d_rdata;
        ifDoneNxt   = 1'b0;
        dDoneNxt    = 1'b0;
        ifErrNxt    = 1'b0;
        dErrNxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (grantD || grantIf) begin
                    ownerNxt    = grantD ? OWN_D : OWN_IF;
                    memAddrNxt  = {grantAddr[63:3], 3'b000};
                    memWdataNxt = grantD ? d_wdata : 64'd0;
                    laneNxt     = grantAddr[2];
                    if (misNow) begin
                        // misaligned: answer immediately, memory is never touched
                        stateNxt  = RESP;
                        dDoneNxt  = grantD;
                        dErrNxt   = grantD;
                        ifDoneNxt = grantIf;
                        ifErrNxt  = grantIf;
                    end else if (grantD && d_we) begin
                        stateNxt  = ACCESS;
                        memWrNxt  = 1'b1;
                        accCntNxt = 3'd0;
                    end else begin
                        stateNxt  = ACCESS;
                        accCntNxt = 3'(MEM_LAT - 1);
                    end
                end
            end
            ACCESS: begin
                if (accCnt == 3'd0) begin
                    stateNxt = RESP;
                    memWrNxt = 1'b0;
                    if (owner == OWN_IF) begin
                        ifDoneNxt  = 1'b1;
                        ifRdataNxt = lane ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else begin
                        dDoneNxt  = 1'b1;
                        dRdataNxt = mem_wr ? 64'd0 : mem_rdata;
                    end
                end else begin
                    accCntNxt = accCnt - 3'd1;
                end
            end
            RESP: begin
                stateNxt = IDLE;
                ownerNxt = OWN_NONE;
            end
            default: begin
                stateNxt = IDLE;
                ownerNxt = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            accCnt    <= '0;
            lane      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_err    <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            state     <= stateNxt;
            owner     <= ownerNxt;
            accCnt    <= accCntNxt;
            lane      <= laneNxt;
            mem_addr  <= memAddrNxt;
            mem_wdata <= memWdataNxt;
            mem_wr    <= memWrNxt;
            if_rdata  <= ifRdataNxt;
            d_rdata   <= dRdataNxt;
            if_done   <= ifDoneNxt;
            d_done    <= dDoneNxt;
            if_err    <= ifErrNxt;
            d_err     <= dErrNxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a two-cycle-latency memory model.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_done, if_err;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_done, d_err;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_err     (d_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [63:0] pattern(input int i);
        if (i == 32) return 64'hDEADBEEF_00000013;
        return {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
    endfunction

    // memory: reloads its pattern while reset is low, rdata valid MEM_LAT cycles after address
    logic [63:0] mem [256];
    logic [63:0] memRdata;
    int          wrTotal = 0;
    assign mem_rdata = memRdata;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else if (mem_wr) begin
            mem[mem_addr[10:3]] <= mem_wdata;
        end
        memRdata <= mem[mem_addr[10:3]];
    end

    always @(negedge clk) if (mem_wr) wrTotal++;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitDone(output bit got, output bit isIf, output longint tDone);
        got = 1'b0; isIf = 1'b0; tDone = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (if_done || d_done) begin
                got   = 1'b1;
                isIf  = if_done;
                tDone = longint'($time / 10);
            end
        end
        checkVal("done_seen", 64'(got), 64'd1);
    endtask

    // issues one request at an IDLE negedge, returns latency in cycles and the response
    task automatic runAccess(input bit isIf, input bit we, input logic [63:0] addr,
                             input logic [63:0] wdata, output int lat,
                             output logic [63:0] rd, output logic err);
        bit     got, wasIf;
        longint t0, t1;
        t0 = longint'($time / 10);
        if (isIf) begin
            if_addr = addr; if_req = 1'b1;
        end else begin
            d_addr = addr; d_we = we; d_wdata = wdata; d_req = 1'b1;
        end
        waitDone(got, wasIf, t1);
        lat = got ? int'(t1 - t0) : 99;
        checkVal("done_owner", 64'(wasIf), 64'(isIf));
        rd  = isIf ? {32'd0, if_rdata} : d_rdata;
        err = isIf ? if_err : d_err;
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          lat, k, nIf, wrBase;
        logic [63:0] rd, expW;
        logic        err;
        bit          got, wasIf;
        longint      t0, t, tFirst, tLast;
        logic [7:0]  order;

        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);

        checkVal("rst_mem_wr", 64'(mem_wr), 64'd0);
        checkVal("rst_mem_addr", mem_addr, 64'd0);
        checkVal("rst_mem_wdata", mem_wdata, 64'd0);
        checkVal("rst_dones", {62'd0, if_done, d_done}, 64'd0);
        checkVal("rst_errs", {62'd0, if_err, d_err}, 64'd0);
        checkVal("rst_if_rdata", 64'(if_rdata), 64'd0);
        checkVal("rst_d_rdata", d_rdata, 64'd0);
        reset = 1'b1;

        // fetch, upper and lower lanes
        runAccess(1'b1, 1'b0, 64'h104, 64'd0, lat, rd, err);
        checkVal("fetch_lat", 64'(lat), 64'd3);
        checkVal("fetch_hi_rdata", rd, 64'hDEADBEEF);
        checkVal("fetch_err", 64'(err), 64'd0);
        checkVal("fetch_mem_addr", mem_addr, 64'h100);
        runAccess(1'b1, 1'b0, 64'h100, 64'd0, lat, rd, err);
        checkVal("fetch_lo_rdata", rd, 64'h00000013);

        // store then load the same word
        wrBase = wrTotal;
        runAccess(1'b0, 1'b1, 64'h200, 64'h1122334455667788, lat, rd, err);
        checkVal("store_lat", 64'(lat), 64'd2);
        checkVal("store_wr_cycles", 64'(wrTotal - wrBase), 64'd1);
        checkVal("store_mem_addr", mem_addr, 64'h200);
        checkVal("store_rdata", rd, 64'd0);
        checkVal("store_err", 64'(err), 64'd0);
        checkVal("store_mem_word", mem[64], 64'h1122334455667788);
        runAccess(1'b0, 1'b0, 64'h200, 64'd0, lat, rd, err);
        checkVal("load_lat", 64'(lat), 64'd3);
        checkVal("load_rdata", rd, 64'h1122334455667788);

        // misaligned accesses
        wrBase = wrTotal;
        runAccess(1'b0, 1'b0, 64'h203, 64'd0, lat, rd, err);
        checkVal("misld_lat", 64'(lat), 64'd1);
        checkVal("misld_err", 64'(err), 64'd1);
        checkVal("misld_mem_addr", mem_addr, 64'h200);
        runAccess(1'b0, 1'b1, 64'h20C, 64'hFFFF_FFFF_FFFF_FFFF, lat, rd, err);
        checkVal("misst_lat", 64'(lat), 64'd1);
        checkVal("misst_err", 64'(err), 64'd1);
        checkVal("mis_wr_cycles", 64'(wrTotal - wrBase), 64'd0);
        checkVal("misst_mem_word", mem[65], pattern(65));
        runAccess(1'b1, 1'b0, 64'h102, 64'd0, lat, rd, err);
        checkVal("misif_lat", 64'(lat), 64'd1);
        checkVal("misif_err", 64'(err), 64'd1);

        // both requesters held: expect D,D,D,IF,D,D,D,IF at one grant every MEM_LAT+2 cycles
        d_we = 1'b0; d_addr = 64'h400; if_addr = 64'h500;
        d_req = 1'b1; if_req = 1'b1;
        t0 = longint'($time / 10);
        k = 0; nIf = 0; order = '0; tFirst = 0; tLast = 0;
        while (k < 8) begin
            waitDone(got, wasIf, t);
            if (!got) break;
            if (k == 0) begin
                tFirst = t;
                checkVal("starve_first_d_rdata", d_rdata, pattern(128));
            end
            tLast = t;
            order[k] = wasIf;
            if (wasIf) begin
                expW = pattern(160);
                checkVal(nIf == 0 ? "starve_if_lane0" : "starve_if_lane1", 64'(if_rdata),
                         nIf == 0 ? {32'd0, expW[31:0]} : {32'd0, expW[63:32]});
                nIf++;
                if_addr = if_addr + 64'd4;
            end else begin
                d_addr = d_addr + 64'd8;
            end
            k++;
        end
        checkVal("starve_order", 64'(order), 64'h88);
        checkVal("starve_first_lat", 64'(tFirst - t0), 64'd3);
        checkVal("starve_interval", 64'(tLast - tFirst), 64'd28);
        d_req = 1'b0; if_req = 1'b0;
        @(negedge clk);

        // reset during the store strobe: no write may land
        d_we = 1'b1; d_addr = 64'h300; d_wdata = 64'h0BAD_0BAD_0BAD_0BAD; d_req = 1'b1;
        @(negedge clk);
        checkVal("rstmid_wr_before", 64'(mem_wr), 64'd1);
        #1 reset = 1'b0;
        #1;
        checkVal("rstmid_wr_async", 64'(mem_wr), 64'd0);
        checkVal("rstmid_mem_addr", mem_addr, 64'd0);
        checkVal("rstmid_mem_wdata", mem_wdata, 64'd0);
        d_req = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        checkVal("rstmid_mem_word", mem[96], pattern(96));
        checkVal("rstmid_idle", {62'd0, mem_wr, d_done}, 64'd0);

        // data owner keeps d_req high with a new address; fetch joins and waits its turn
        d_we = 1'b0; d_addr = 64'h210; d_req = 1'b1;
        t0 = longint'($time / 10);
        waitDone(got, wasIf, t);
        checkVal("keep_first_lat", 64'(t - t0), 64'd3);
        checkVal("keep_first_rdata", d_rdata, pattern(66));
        d_addr = 64'h208; if_addr = 64'h600; if_req = 1'b1;
        tLast = t;
        waitDone(got, wasIf, t);
        checkVal("keep_second_owner", 64'(wasIf), 64'd0);
        checkVal("keep_second_gap", 64'(t - tLast), 64'd4);
        checkVal("keep_second_rdata", d_rdata, pattern(65));
        d_req = 1'b0;
        tLast = t;
        waitDone(got, wasIf, t);
        checkVal("keep_if_owner", 64'(wasIf), 64'd1);
        checkVal("keep_if_gap", 64'(t - tLast), 64'd4);
        expW = pattern(192);
        checkVal("keep_if_rdata", 64'(if_rdata), {32'd0, expW[31:0]});
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares one 64-bit memory port between the instruction-fetch requester (PC/IR path) and the data load/store requester (ALUOut/B/MDR path) of the multicycle RISC-V core.
- Replaces the split instruction/data memories with a single Memoria64-style port.
- Applies fixed data-over-fetch priority, with a starvation bound for fetch.
- Handles the memory's read latency, fetch word-lane selection, and data alignment checking.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from address valid to rdata valid; legal range 1..7.
- STARVE_MAX, 3, consecutive data grants allowed while fetch is pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; level, held until if_done.
- if_addr  in  64  fetch byte address; stable while if_req=1.
- if_rdata  out  32  fetched instruction; valid when if_done=1.
- if_done  out  1  one-cycle completion pulse.
- if_err  out  1  misaligned fetch (if_addr[1:0]!=0); qualified by if_done.
- d_req  in  1  data request; level, held until d_done.
- d_we  in  1  1=store, 0=load; stable while d_req=1.
- d_addr  in  64  data byte address; stable while d_req=1.
- d_wdata  in  64  store data.
- d_rdata  out  64  load data; valid when d_done=1.
- d_done  out  1  one-cycle completion pulse.
- d_err  out  1  misaligned data access (d_addr[2:0]!=0); qualified by d_done.
- mem_addr  out  64  memory address, always 8-byte aligned.
- mem_wdata  out  64  memory write data.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  64  memory read data.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, owner=NONE, starve_cnt=0. All outputs 0, including mem_wr, the done/err pulses, and the rdata/addr registers. Any in-flight access is abandoned; requesters re-issue after reset. A reset mid-store deasserts mem_wr immediately.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE, arbitration on each clock edge:
  - Only d_req set: grant data.
  - Only if_req set: grant fetch.
  - Both set: grant fetch if starve_cnt==STARVE_MAX, else grant data.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each data grant while if_req=1.
  - Clears on any fetch grant.
  - Holds otherwise.
- On a grant:
  - Latch the owner.
  - Set mem_addr={addr[63:3],3'b000}.
  - Set mem_wdata=d_wdata for data grants, otherwise 0.
  - Capture addr[2] for fetch lane selection.
- Misaligned grant: go directly to RESP with err=1. No ACCESS cycle, mem_wr stays 0, memory contents are unchanged.
- Aligned store: ACCESS lasts exactly 1 cycle with mem_wr=1, then RESP.
- Aligned load or fetch: ACCESS lasts MEM_LAT cycles with mem_wr=0, using a down-counter loaded with MEM_LAT-1. mem_rdata is sampled at the final ACCESS edge.
- RESP (one cycle):
  - The owner's done=1.
  - Fetch: if_rdata = lane ? mem_rdata[63:32] : mem_rdata[31:0] (little-endian).
  - Data load: d_rdata = mem_rdata. Store: d_rdata = 0.
  - Next state is IDLE. Requests are not sampled in RESP.
- Latency from the grant edge to the done cycle:
  - Load/fetch: MEM_LAT+1.
  - Store: 2.
  - Misaligned: 1.
  - Minimum issue interval: MEM_LAT+2 cycles per read.
- Requester rules:
  - A requester may keep req high after done to issue a new request, with new addr/we/wdata from the cycle after done. It is re-arbitrated in IDLE.
  - A non-owner's req held during a transaction is not lost; it is arbitrated in the next IDLE.
- rdata registers hold their last value between transactions. done and err are 0 outside RESP.
- mem_addr and mem_wdata hold their values between transactions; only mem_wr is strobed.
- Simultaneous new requests arriving in RESP wait until IDLE.

Decomposition:
- Shared package core_pkg:
  - typedef enum {IDLE, ACCESS, RESP} arb_state_t
  - typedef enum {OWN_NONE, OWN_IF, OWN_D} arb_owner_t
  - localparam WORD_ALIGN_MASK=3'b111
  - localparam INSTR_ALIGN_MASK=2'b11
- One sub-module, arb_starve_ctr: a saturating counter with inc/clr and a hit=(cnt==STARVE_MAX) output. The FSM, lane mux, and alignment checks stay in mem_port_arbiter.

Test Plan:
- MEM_LAT=2, only if_req, if_addr=0x104, mem word@0x100=0xDEADBEEF_00000013 → if_done 3 cycles after the grant edge, if_rdata=0xDEADBEEF, if_err=0.
- Store d_addr=0x200, d_wdata=0x1122334455667788, then load 0x200 → exactly one mem_wr cycle with mem_addr=0x200; load returns d_rdata=0x1122334455667788.
- if_req and d_req both held continuously, STARVE_MAX=3 → grant order D,D,D,IF,D,D,D,IF; starve_cnt clears on each IF grant.
- d_addr=0x203 load → d_done with d_err=1 one cycle after the grant, mem_wr never asserted; if_addr=0x102 → if_err=1.
- Pull reset low during store ACCESS → mem_wr falls asynchronously, all outputs 0, state IDLE; memory at the target address is unmodified if released before the edge.
- Owner keeps d_req high after d_done with a new address 0x208 → exactly one idle cycle, then a new data grant; a pending if_req is arbitrated per starve_cnt.
